// File: rtl/jk_drive_gen.sv
// Drive generator for a WIDTH-bit JK flip-flop bank: buffers target words in a FIFO,
// turns each into J/K drive vectors and checks the bank's fed-back Q.
module jk_drive_gen #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int TOG_PREF = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             drv_en,
    output logic             busy,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  model_q, model_d;
    logic [WIDTH-1:0]  expected_q, expected_d;
    logic [WIDTH-1:0]  j_q, j_d;
    logic [WIDTH-1:0]  k_q, k_d;
    logic              drv_q, drv_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              push;
    logic              pop;
    logic              load;
    logic              fifo_empty;
    logic [WIDTH-1:0]  head;
    logic [WIDTH-1:0]  base;

    // Change bits either force the new value (J1K0 / J0K1) or simply toggle (J1K1).
    function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] m,
                                               input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        rise = t & ~m;
        fall = m & ~t;
        return (TOG_PREF != 0) ? (rise | fall) : rise;
    endfunction

    function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] m,
                                               input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        rise = t & ~m;
        fall = m & ~t;
        return (TOG_PREF != 0) ? (rise | fall) : fall;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        model_d    = model_q;
        expected_d = expected_q;
        j_d        = '0;
        k_d        = '0;
        drv_d      = 1'b0;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        pop        = 1'b0;
        load       = 1'b0;
        base       = model_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            S_DRIVE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // The bank has taken the drive by now; resync the model to what it really holds.
                if (q_fb != expected_q) begin
                    err_d     = 1'b1;
                    err_cnt_d = (err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
                    model_d   = q_fb;
                end else begin
                    model_d   = expected_q;
                end
                base = model_d;
                if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            pop        = 1'b1;
            state_d    = S_DRIVE;
            j_d        = exc_j(base, head);
            k_d        = exc_k(base, head);
            drv_d      = 1'b1;
            expected_d = head;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            model_q    <= '0;
            expected_q <= '0;
            j_q        <= '0;
            k_q        <= '0;
            drv_q      <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            model_q    <= model_d;
            expected_q <= expected_d;
            j_q        <= j_d;
            k_q        <= k_d;
            drv_q      <= drv_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign j_out   = j_q;
    assign k_out   = k_q;
    assign drv_en  = drv_q;
    assign busy    = (state_q != S_IDLE) || !fifo_empty;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_jk_drive_gen.sv
// Directed bench for jk_drive_gen: JK bank models close the loop on q_fb for a
// forcing instance and a toggle-preference instance sharing one input stream.
module tb_jk_drive_gen;

    logic       clk = 1'b0;
    logic       res;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready, in_ready_t;
    logic [7:0] j_out, k_out, j_out_t, k_out_t;
    logic       drv_en, drv_en_t, busy, busy_t, err, err_t;
    logic [7:0] err_cnt, err_cnt_t;

    logic [7:0] bank, bank_t;
    logic [7:0] q_fb, q_fb_t;
    logic       force_en;
    logic [7:0] force_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_drive_gen #(.WIDTH(8), .DEPTH(4), .TOG_PREF(0)) u_dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .q_fb(q_fb), .j_out(j_out), .k_out(k_out),
        .drv_en(drv_en), .busy(busy), .err(err), .err_cnt(err_cnt)
    );

    jk_drive_gen #(.WIDTH(8), .DEPTH(4), .TOG_PREF(1)) u_dut_t (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_data(in_data), .q_fb(q_fb_t), .j_out(j_out_t), .k_out(k_out_t),
        .drv_en(drv_en_t), .busy(busy_t), .err(err_t), .err_cnt(err_cnt_t)
    );

    // JK bank behaviour: Q+ = J & ~Q | ~K & Q, reset by the same res.
    always @(posedge clk) begin
        if (res) begin
            bank   <= 8'h00;
            bank_t <= 8'h00;
        end else begin
            bank   <= (j_out & ~bank) | (~k_out & bank);
            bank_t <= (j_out_t & ~bank_t) | (~k_out_t & bank_t);
        end
    end

    assign q_fb   = force_en ? force_val : bank;
    assign q_fb_t = bank_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drv(input string name);
        int n;
        n = 0;
        while (drv_en !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (drv_en !== 1'b1) begin
            errors++;
            $display("FAIL %s: drv_en got %b want 1 within 40 cycles", name, drv_en);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy got %b want 0 within 40 cycles", name, busy);
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        res       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        force_en  = 1'b0;
        force_val = 8'h00;
        tick();
        tick();
        res = 1'b0;
        tick();
        checks++;
        if (j_out !== 8'h00 || k_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_jk: got j=%h k=%h want 00/00", j_out, k_out);
        end
        checks++;
        if (drv_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got drv_en=%b busy=%b want 0/0", drv_en, busy);
        end
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_err: got err=%b cnt=%0d want 0/0", err, err_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    // Accept at one edge, DRIVE on the next: checks minimum latency as well as excitation.
    task automatic test_single_word();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (drv_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_queued: got drv_en=%b busy=%b want 0/1", drv_en, busy);
        end
        tick();
        checks++;
        if (drv_en !== 1'b1 || j_out !== 8'hA5 || k_out !== 8'h00) begin
            errors++;
            $display("FAIL t1_drive: got drv_en=%b j=%h k=%h want 1 A5 00", drv_en, j_out, k_out);
        end
        checks++;
        if (j_out_t !== 8'hA5 || k_out_t !== 8'hA5) begin
            errors++;
            $display("FAIL t1_drive_tog: got j=%h k=%h want A5 A5", j_out_t, k_out_t);
        end
        tick();
        checks++;
        if (drv_en !== 1'b0 || j_out !== 8'h00 || k_out !== 8'h00) begin
            errors++;
            $display("FAIL t1_settle: got drv_en=%b j=%h k=%h want 0 00 00", drv_en, j_out, k_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL t1_done: got busy=%b err=%b want 0/0", busy, err);
        end
    endtask

    task automatic test_excitation();
        push_one(8'h3C);
        wait_drv("t2_wait");
        checks++;
        if (j_out !== 8'h18 || k_out !== 8'h81) begin
            errors++;
            $display("FAIL t2_jk: got j=%h k=%h want 18 81", j_out, k_out);
        end
        checks++;
        if (j_out_t !== 8'h99 || k_out_t !== 8'h99) begin
            errors++;
            $display("FAIL t2_jk_tog: got j=%h k=%h want 99 99", j_out_t, k_out_t);
        end
        wait_idle("t2_idle");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL t2_err: got %b want 0", err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [8];
        logic [7:0] exp_j [8];
        logic [7:0] exp_k [8];
        bit saw_full;
        words = '{8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h55, 8'hAA};
        exp_j = '{8'h00, 8'hFF, 8'h00, 8'hF0, 8'h03, 8'hCC, 8'h11, 8'hAA};
        exp_k = '{8'h3C, 8'h00, 8'hF0, 8'h0F, 8'hC0, 8'h33, 8'h88, 8'h55};
        saw_full = 1'b0;
        fork
            begin : pusher
                int n;
                in_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    in_data = words[i];
                    n = 0;
                    while (in_ready !== 1'b1 && n < 40) begin
                        saw_full = 1'b1;
                        tick();
                        n++;
                    end
                    tick();
                end
                in_valid = 1'b0;
            end
            begin : watcher
                int cyc;
                int last;
                int n;
                cyc  = 0;
                last = 0;
                for (int i = 0; i < 8; i++) begin
                    n = 0;
                    while (drv_en !== 1'b1 && n < 40) begin
                        tick();
                        cyc++;
                        n++;
                    end
                    checks++;
                    if (drv_en !== 1'b1 || j_out !== exp_j[i] || k_out !== exp_k[i]) begin
                        errors++;
                        $display("FAIL t3_word%0d: got drv_en=%b j=%h k=%h want 1 %h %h",
                                 i, drv_en, j_out, k_out, exp_j[i], exp_k[i]);
                    end
                    if (i > 0) begin
                        checks++;
                        if (cyc - last != 2) begin
                            errors++;
                            $display("FAIL t3_gap%0d: got %0d cycles want 2", i, cyc - last);
                        end
                    end
                    last = cyc;
                    tick();
                    cyc++;
                end
            end
        join
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("FAIL t3_full: in_ready low seen=%b want 1", saw_full);
        end
        wait_idle("t3_idle");
    endtask

    task automatic test_mismatch();
        push_one(8'h0F);
        wait_drv("t4_wait");
        checks++;
        if (j_out !== 8'h05 || k_out !== 8'hA0) begin
            errors++;
            $display("FAIL t4_jk: got j=%h k=%h want 05 A0", j_out, k_out);
        end
        force_en  = 1'b1;
        force_val = 8'hFF;
        tick();
        tick();
        force_en = 1'b0;
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL t4_err: got err=%b cnt=%0d want 1/1", err, err_cnt);
        end
        push_one(8'h00);
        wait_drv("t4_wait2");
        checks++;
        if (j_out !== 8'h00 || k_out !== 8'hFF) begin
            errors++;
            $display("FAIL t4_resync: got j=%h k=%h want 00 FF", j_out, k_out);
        end
        wait_idle("t4_idle");
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL t4_sticky: got err=%b cnt=%0d want 1/1", err, err_cnt);
        end
    endtask

    task automatic test_saturate();
        int n;
        force_en  = 1'b1;
        force_val = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            while (in_ready !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            tick();
        end
        in_valid = 1'b0;
        wait_idle("t5_idle");
        force_en = 1'b0;
        checks++;
        if (err_cnt !== 8'd255 || err !== 1'b1) begin
            errors++;
            $display("FAIL t5_sat: got err=%b cnt=%0d want 1/255", err, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || drv_en !== 1'b0) begin
            errors++;
            $display("FAIL t6_pre: got busy=%b drv_en=%b want 1/0", busy, drv_en);
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        checks++;
        if (j_out !== 8'h00 || k_out !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL t6_reset: got j=%h k=%h busy=%b ready=%b want 00 00 0 1",
                     j_out, k_out, busy, in_ready);
        end
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0 || drv_en !== 1'b0) begin
            errors++;
            $display("FAIL t6_clear: got err=%b cnt=%0d drv_en=%b want 0 0 0", err, err_cnt, drv_en);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (drv_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL t6_flushed%0d: got drv_en=%b busy=%b want 0/0", i, drv_en, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_excitation();
        test_back_to_back();
        test_mismatch();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
